poly_step_sequencer: RTL

- Parametrised polyphonic step sequencer for the Tang Nano board: an NSTEPS x NVOICES note grid, edited with a cursor and buttons, then played back at a programmable tempo.
- Drives the 8x8 LED matrix (rows = steps, paged in groups of 8; columns = voices).
- Mixes active voices into a 1-bit sigma-delta audio stream.
- Generalises the fixed 16x8 sequencer with tempo, runtime tone divisors, press-edge editing and true mixing.

---
 rtl/poly_step_sequencer_pkg.sv | 18 +
 rtl/poly_step_sequencer_if.sv | 26 ++
 rtl/poly_step_sequencer_tone_gen.sv | 25 ++
 rtl/poly_step_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/poly_step_sequencer_pkg.sv
// seq_pkg: shared constants, button bundle type and width helper for the step sequencer
package seq_pkg;
  localparam int ROWS = 8;
  localparam logic [7:0][15:0] DEF_DIV = {16'd15341, 16'd17219, 16'd19341, 16'd20486,
                                          16'd22998, 16'd25813, 16'd27328, 16'd30682};
  localparam logic [23:0] DEF_STEP_PERIOD = 24'd6_750_000;
  typedef struct packed {
    logic clr;
    logic set;
    logic right;
    logic left;
    logic down;
    logic up;
  } btn_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/poly_step_sequencer_if.sv
// poly_step_sequencer_if: controls in, matrix/audio/cursor status out
interface poly_step_sequencer_if #(
  parameter int NSTEPS  = 16,
  parameter int NVOICES = 8,
  parameter int DIV_W   = 16,
  parameter int TEMPO_W = 24
);
  import seq_pkg::*;
  localparam int SW = idx_w(NSTEPS);
  localparam int XW = idx_w(NVOICES);
  logic                     play;
  logic                     btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_set_n, btn_clr_n;
  logic [TEMPO_W-1:0]       step_period;
  logic [NVOICES*DIV_W-1:0] tone_div;
  logic [NVOICES-1:0]       col;
  logic [ROWS-1:0]          row;
  logic                     audio;
  logic [SW-1:0]            step_idx, cur_y;
  logic [XW-1:0]            cur_x;
  modport master (output play, btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_set_n, btn_clr_n,
                         step_period, tone_div,
                  input  col, row, audio, step_idx, cur_x, cur_y);
  modport slave  (input  play, btn_up_n, btn_down_n, btn_left_n, btn_right_n, btn_set_n, btn_clr_n,
                         step_period, tone_div,
                  output col, row, audio, step_idx, cur_x, cur_y);
endinterface

// File: rtl/poly_step_sequencer_tone_gen.sv
// seq_tone_gen: square wave toggling every div clocks; div = 0 silences the voice
module seq_tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             sq
);
  logic [DIV_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (div == '0) begin
      cnt <= '0;
      sq  <= 1'b0;
    end else if (cnt >= div - DIV_W'(1)) begin
      cnt <= '0;
      sq  <= ~sq;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/poly_step_sequencer.sv
// poly_step_sequencer: cursor-edited note grid, tempo playback, sigma-delta voice mixer
// and a paged 8-row LED matrix scan.
module poly_step_sequencer
  import seq_pkg::*;
#(
  parameter int NSTEPS    = 16,
  parameter int NVOICES   = 8,
  parameter int DIV_W     = 16,
  parameter int TEMPO_W   = 24,
  parameter int SCAN_BITS = 13
) (
  input logic clk,
  input logic rst,
  poly_step_sequencer_if.slave bus
);
  localparam int SW = idx_w(NSTEPS);
  localparam int XW = idx_w(NVOICES);
  localparam int AW = $clog2(2 * NVOICES);
  btn_t                            b_q, b_qq, press;
  logic                            play_q, play_qq, edit;
  logic [NSTEPS-1:0][NVOICES-1:0] grid;
  logic [SW-1:0]                   cur_y, step, y_up, y_dn, sel, base, disp;
  logic [XW-1:0]                   cur_x, x_l, x_r;
  logic [TEMPO_W-1:0]              tcnt, period;
  logic [NVOICES-1:0]              sq, hot, cur_mask, play_mask, col;
  logic [AW-1:0]                   acc, sum;
  logic                            audio, blink;
  logic [SCAN_BITS+8:0]            scan;
  logic [2:0]                      r;
  logic [ROWS-1:0]                 row;
  assign press = b_qq & ~b_q;
  assign edit  = ~play_q;
  always_comb begin
    y_up      = cur_y == '0 ? SW'(NSTEPS - 1) : cur_y - SW'(1);
    y_dn      = cur_y == SW'(NSTEPS - 1) ? '0 : cur_y + SW'(1);
    x_l       = cur_x == '0 ? XW'(NVOICES - 1) : cur_x - XW'(1);
    x_r       = cur_x == XW'(NVOICES - 1) ? '0 : cur_x + XW'(1);
    period    = bus.step_period == '0 ? TEMPO_W'(1) : bus.step_period;
    hot       = grid[step] & sq;
    sum       = acc + AW'($countones(hot));
    r         = scan[SCAN_BITS+2:SCAN_BITS];
    blink     = scan[SCAN_BITS+8];
    sel       = play_q ? step : cur_y;
    base      = sel & ~SW'(7);
    disp      = base + SW'(r);
    cur_mask  = (edit && blink && r == cur_y[2:0]) ? NVOICES'(1) << cur_x : '0;
    play_mask = (play_q && disp == step) ? '1 : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_q     <= '1;
      b_qq    <= '1;
      play_q  <= 1'b0;
      play_qq <= 1'b0;
    end else begin
      b_q     <= {bus.btn_clr_n, bus.btn_set_n, bus.btn_right_n, bus.btn_left_n, bus.btn_down_n, bus.btn_up_n};
      b_qq    <= b_q;
      play_q  <= bus.play;
      play_qq <= play_q;
    end
  end
  // Writes address the cursor as it stood before any simultaneous move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grid  <= '0;
      cur_x <= '0;
      cur_y <= '0;
    end else if (edit) begin
      if (press.set ^ press.clr) grid[cur_y][cur_x] <= press.set;
      cur_y <= (press.up & ~press.down) ? y_up : (press.down & ~press.up) ? y_dn : cur_y;
      cur_x <= (press.left & ~press.right) ? x_l : (press.right & ~press.left) ? x_r : cur_x;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
      step <= '0;
    end else if (play_q & ~play_qq) begin
      tcnt <= '0;
      step <= '0;
    end else if (play_q) begin
      tcnt <= tcnt >= period - TEMPO_W'(1) ? '0 : tcnt + TEMPO_W'(1);
      if (tcnt >= period - TEMPO_W'(1)) step <= step == SW'(NSTEPS - 1) ? '0 : step + SW'(1);
    end
  end
  for (genvar g = 0; g < NVOICES; g++) begin : g_tone
    seq_tone_gen #(.DIV_W(DIV_W)) u_tone (
      .clk(clk),
      .rst(rst),
      .div(bus.tone_div[g*DIV_W +: DIV_W]),
      .sq (sq[g])
    );
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      audio <= 1'b0;
    end else begin
      audio <= play_q && sum >= AW'(NVOICES);
      acc   <= !play_q ? '0 : sum >= AW'(NVOICES) ? sum - AW'(NVOICES) : sum;
    end
  end
  // Row and column latch on the same edge so a row change never shows stale columns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan <= '0;
      col  <= '0;
      row  <= 8'hFE;
    end else begin
      scan <= scan + 1'b1;
      col  <= grid[disp] ^ cur_mask ^ play_mask;
      row  <= ~(8'd1 << r);
    end
  end
  assign bus.col      = col;
  assign bus.row      = row;
  assign bus.audio    = audio;
  assign bus.step_idx = step;
  assign bus.cur_x    = cur_x;
  assign bus.cur_y    = cur_y;
endmodule
